// File: rtl/snake_fb_pkg.sv
// Shared constants, state type and address helper for the snake tile-map writer.
package snake_fb_pkg;

   localparam int unsigned GRID_W     = 32;
   localparam int unsigned GRID_H     = 24;
   localparam int unsigned CELL_COUNT = GRID_W * GRID_H;
   localparam int unsigned ADDR_W     = 10;
   localparam int unsigned COORD_W    = 5;

   typedef enum logic [0:0] {
      FB_IDLE,
      FB_CLEAR
   } fb_state_t;

   // Map address layout shared with the display read path: {row, column}.
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read data; push and pop may coincide when full.
module sync_fifo #(
   parameter int unsigned WIDTH = 15,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/snake_fb_writer.sv
// Write-side engine for the 32x24 snake tile map: buffered cell draws and full-map clears.
// Optional build macro SNAKE_FB_VBLANK_ONLY_EN restricts memory writes to vblank cycles.
module snake_fb_writer
   import snake_fb_pkg::*;
#(
   parameter int unsigned DATA_W     = 5,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [4:0]        req_x,
   input  logic [4:0]        req_y,
   input  logic [DATA_W-1:0] req_data,
   input  logic              clear_start,
   input  logic [DATA_W-1:0] clear_data,
   input  logic              vblank,
   output logic              we,
   output logic [9:0]        waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              drop
);

   localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

   fb_state_t          state;
   fb_state_t          state_next;
   logic [ADDR_W-1:0]  sweep_cnt;
   logic [ADDR_W-1:0]  sweep_cnt_next;
   logic [DATA_W-1:0]  clr_data;
   logic [DATA_W-1:0]  clr_data_next;
   logic               we_next;
   logic [ADDR_W-1:0]  waddr_next;
   logic [DATA_W-1:0]  wdata_next;

   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_dout;

   logic               accept_c;
   logic               in_range_c;
   logic               gate_c;

   // Write gate: either every cycle or only during vertical blanking.
`ifdef SNAKE_FB_VBLANK_ONLY_EN
   assign gate_c = vblank;
`else
   logic unused_vblank;
   assign gate_c        = 1'b1;
   assign unused_vblank = vblank;
`endif

   // Handshake and range check; bad rows complete the handshake but are not queued.
   assign req_ready  = ~fifo_full;
   assign accept_c   = req_valid & req_ready;
   assign in_range_c = (req_y < COORD_W'(GRID_H));
   assign fifo_push  = accept_c & in_range_c;
   assign fifo_din   = {cell_addr(req_x, req_y), req_data};

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (fifo_din),
      .rdata (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state and write selection: clear sweep has priority over queued draws.
   always_comb begin
      state_next     = state;
      sweep_cnt_next = sweep_cnt;
      clr_data_next  = clr_data;
      we_next        = 1'b0;
      waddr_next     = waddr;
      wdata_next     = wdata;
      fifo_pop       = 1'b0;

      case (state)
         FB_IDLE: begin
            if (clear_start) begin
               state_next     = FB_CLEAR;
               sweep_cnt_next = '0;
               clr_data_next  = clear_data;
            end else if (!fifo_empty && gate_c) begin
               fifo_pop   = 1'b1;
               we_next    = 1'b1;
               waddr_next = fifo_dout[ENTRY_W-1 -: ADDR_W];
               wdata_next = fifo_dout[DATA_W-1:0];
            end
         end
         FB_CLEAR: begin
            if (gate_c) begin
               we_next    = 1'b1;
               waddr_next = sweep_cnt;
               wdata_next = clr_data;
               if (sweep_cnt == ADDR_W'(CELL_COUNT - 1)) begin
                  state_next     = FB_IDLE;
                  sweep_cnt_next = '0;
               end else begin
                  sweep_cnt_next = sweep_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_next = FB_IDLE;
         end
      endcase
   end

   // State, sweep counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FB_IDLE;
         sweep_cnt <= '0;
         clr_data  <= '0;
         we        <= 1'b0;
         waddr     <= '0;
         wdata     <= '0;
         busy      <= 1'b0;
         drop      <= 1'b0;
      end else begin
         state     <= state_next;
         sweep_cnt <= sweep_cnt_next;
         clr_data  <= clr_data_next;
         we        <= we_next;
         waddr     <= waddr_next;
         wdata     <= wdata_next;
         busy      <= (state == FB_CLEAR) | ~fifo_empty;
         drop      <= accept_c & ~in_range_c;
      end
   end

endmodule
